// File: rtl/mm_pkg.sv
// Shared types and helpers for the Mastermind scoring engine: FSM state,
// count-width helpers and a peg extractor over a max-size packed vector.
package mm_pkg;

    typedef enum logic [1:0] {IDLE, RED, WHITE, DONE} mm_state_t;

    localparam int MAX_PEGS    = 8;
    localparam int MAX_COLOR_W = 8;
    localparam int MAX_BITS    = MAX_PEGS * MAX_COLOR_W;

    function automatic int count_w(input int num_pegs);
        return $clog2(num_pegs + 1);
    endfunction

    function automatic int guess_w(input int max_guesses);
        return $clog2(max_guesses + 1);
    endfunction

    // Callers zero-extend their packed code into MAX_BITS; colour bits above
    // color_w come back as zero so full-width compares stay exact.
    function automatic logic [MAX_COLOR_W-1:0] peg_at(input logic [MAX_BITS-1:0] vec,
                                                      input int idx, input int color_w);
        logic [MAX_BITS-1:0]    shifted;
        logic [MAX_COLOR_W-1:0] peg;
        shifted = vec >> (idx * color_w);
        peg = '0;
        for (int b = 0; b < MAX_COLOR_W; b++) begin
            if (b < color_w) peg[b] = shifted[b];
        end
        return peg;
    endfunction

endpackage

// File: rtl/mm_first_match.sv
// Priority finder: lowest guess peg that is not yet used and has the given colour.
module mm_first_match
    import mm_pkg::*;
#(
    parameter int NUM_PEGS = 4,
    parameter int COLOR_W  = 3
) (
    input  logic [COLOR_W-1:0]          colour,
    input  logic [NUM_PEGS*COLOR_W-1:0] guess,
    input  logic [NUM_PEGS-1:0]         used,
    output logic                        found,
    output logic [NUM_PEGS-1:0]         onehot
);

    logic [MAX_BITS-1:0]    guess_ext;
    logic [MAX_COLOR_W-1:0] peg;

    always_comb begin
        guess_ext = '0;
        guess_ext[NUM_PEGS*COLOR_W-1:0] = guess;
        found  = 1'b0;
        onehot = '0;
        peg    = '0;
        for (int j = 0; j < NUM_PEGS; j++) begin
            peg = peg_at(guess_ext, j, COLOR_W);
            if (!found && !used[j] && (peg == MAX_COLOR_W'(colour))) begin
                onehot[j] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mm_score_engine.sv
// Mastermind feedback engine: scores one guess with a two-phase red/white
// scan and tracks guess count and the sticky win/lose state of the game.
module mm_score_engine
    import mm_pkg::*;
#(
    parameter int NUM_PEGS    = 4,
    parameter int COLOR_W     = 3,
    parameter int MAX_GUESSES = 8,
    localparam int CW = count_w(NUM_PEGS),
    localparam int GW = guess_w(MAX_GUESSES)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        new_game,
    input  logic [NUM_PEGS*COLOR_W-1:0] code,
    input  logic [NUM_PEGS*COLOR_W-1:0] guess,
    output logic                        busy,
    output logic                        done,
    output logic [CW-1:0]               red,
    output logic [CW-1:0]               white,
    output logic [GW-1:0]               guess_count,
    output logic                        win,
    output logic                        lose
);

    localparam int KW = $clog2(NUM_PEGS);
    localparam int PW = NUM_PEGS * COLOR_W;

    // Handshake: start is taken only in IDLE with no game over and no new_game;
    // busy then stays high until the end of the single-cycle done pulse, and
    // red/white/guess_count/win/lose are valid from the done cycle onward.
    mm_state_t            state;
    logic [KW-1:0]        k;
    logic [PW-1:0]        cg;
    logic [PW-1:0]        gg;
    logic [NUM_PEGS-1:0]  code_used;
    logic [NUM_PEGS-1:0]  guess_used;
    logic [CW-1:0]        red_acc;
    logic [CW-1:0]        white_acc;

    logic [MAX_BITS-1:0]    cg_ext;
    logic [MAX_BITS-1:0]    gg_ext;
    logic [MAX_COLOR_W-1:0] code_peg;
    logic [MAX_COLOR_W-1:0] guess_peg;
    logic                   exact_hit;
    logic                   white_hit;
    logic                   last_peg;
    logic                   accept;
    logic                   win_next;
    logic                   lose_next;
    logic                   match_found;
    logic [NUM_PEGS-1:0]    match_onehot;
    logic [CW-1:0]          white_final;
    logic [GW-1:0]          count_next;

    always_comb begin
        cg_ext = '0;
        cg_ext[PW-1:0] = cg;
        gg_ext = '0;
        gg_ext[PW-1:0] = gg;
        code_peg  = peg_at(cg_ext, int'(k), COLOR_W);
        guess_peg = peg_at(gg_ext, int'(k), COLOR_W);
    end

    mm_first_match #(
        .NUM_PEGS (NUM_PEGS),
        .COLOR_W  (COLOR_W)
    ) u_first_match (
        .colour (code_peg[COLOR_W-1:0]),
        .guess  (gg),
        .used   (guess_used),
        .found  (match_found),
        .onehot (match_onehot)
    );

    assign exact_hit   = (code_peg == guess_peg);
    assign white_hit   = !code_used[k] && match_found;
    assign last_peg    = (k == KW'(NUM_PEGS - 1));
    assign accept      = start && !win && !lose;
    assign white_final = white_acc + CW'(white_hit);
    assign win_next    = (red_acc == CW'(NUM_PEGS));
    assign lose_next   = !win_next && ((guess_count + GW'(1)) == GW'(MAX_GUESSES));
    assign count_next  = (guess_count == GW'(MAX_GUESSES)) ? guess_count
                                                           : guess_count + GW'(1);

    // Results are registered on the final WHITE step so they appear together
    // with done in the DONE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            k           <= '0;
            cg          <= '0;
            gg          <= '0;
            code_used   <= '0;
            guess_used  <= '0;
            red_acc     <= '0;
            white_acc   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            red         <= '0;
            white       <= '0;
            guess_count <= '0;
            win         <= 1'b0;
            lose        <= 1'b0;
        end else if (new_game) begin
            state       <= IDLE;
            k           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            red         <= '0;
            white       <= '0;
            guess_count <= '0;
            win         <= 1'b0;
            lose        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cg         <= code;
                        gg         <= guess;
                        code_used  <= '0;
                        guess_used <= '0;
                        red_acc    <= '0;
                        white_acc  <= '0;
                        k          <= '0;
                        busy       <= 1'b1;
                        state      <= RED;
                    end
                end
                RED: begin
                    if (exact_hit) begin
                        code_used[k]  <= 1'b1;
                        guess_used[k] <= 1'b1;
                        red_acc       <= red_acc + CW'(1);
                    end
                    if (last_peg) begin
                        k     <= '0;
                        state <= WHITE;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                WHITE: begin
                    if (white_hit) begin
                        guess_used <= guess_used | match_onehot;
                        white_acc  <= white_final;
                    end
                    if (last_peg) begin
                        k           <= '0;
                        state       <= DONE;
                        done        <= 1'b1;
                        red         <= red_acc;
                        white       <= white_final;
                        guess_count <= count_next;
                        win         <= win | win_next;
                        lose        <= lose | lose_next;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mm_score_engine.sv
// Bench for mm_score_engine: a 4-peg/3-bit and a 6-peg/4-bit instance scored
// against a colour-count reference model, plus directed handshake scenarios.
module tb_mm_score_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start4, new_game4, start6, new_game6;
    logic [11:0] code4, guess4;
    logic [23:0] code6, guess6;
    logic        busy4, done4, win4, lose4;
    logic        busy6, done6, win6, lose6;
    logic [2:0]  red4, white4, red6, white6;
    logic [3:0]  gc4, gc6;

    logic        cur6 = 1'b0;
    logic        obs_busy, obs_done, obs_win, obs_lose;
    logic [2:0]  obs_red, obs_white;
    logic [3:0]  obs_gc;

    int errors = 0;
    int checks = 0;
    int m_gc[2];
    int m_win[2];
    int m_lose[2];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    mm_score_engine #(.NUM_PEGS(4), .COLOR_W(3), .MAX_GUESSES(8)) dut (
        .clk(clk), .reset(reset), .start(start4), .new_game(new_game4),
        .code(code4), .guess(guess4), .busy(busy4), .done(done4),
        .red(red4), .white(white4), .guess_count(gc4), .win(win4), .lose(lose4)
    );

    mm_score_engine #(.NUM_PEGS(6), .COLOR_W(4), .MAX_GUESSES(8)) dut6 (
        .clk(clk), .reset(reset), .start(start6), .new_game(new_game6),
        .code(code6), .guess(guess6), .busy(busy6), .done(done6),
        .red(red6), .white(white6), .guess_count(gc6), .win(win6), .lose(lose6)
    );

    assign obs_busy  = cur6 ? busy6  : busy4;
    assign obs_done  = cur6 ? done6  : done4;
    assign obs_win   = cur6 ? win6   : win4;
    assign obs_lose  = cur6 ? lose6  : lose4;
    assign obs_red   = cur6 ? red6   : red4;
    assign obs_white = cur6 ? white6 : white4;
    assign obs_gc    = cur6 ? gc6    : gc4;

    // Reference: red = positional matches; white = sum over colours of the
    // smaller occurrence count, minus red.
    function automatic void ref_rw(input int n, input int cw, input logic [23:0] c,
                                   input logic [23:0] g, output int r, output int w);
        int cc[16];
        int gc[16];
        int a, b, tot;
        logic [23:0] mask, s;
        mask = 24'((1 << cw) - 1);
        for (int i = 0; i < 16; i++) begin
            cc[i] = 0;
            gc[i] = 0;
        end
        r = 0;
        for (int i = 0; i < n; i++) begin
            s = (c >> (i * cw)) & mask;
            a = int'(s);
            s = (g >> (i * cw)) & mask;
            b = int'(s);
            if (a == b) r++;
            cc[a]++;
            gc[b]++;
        end
        tot = 0;
        for (int i = 0; i < 16; i++) tot += (cc[i] < gc[i]) ? cc[i] : gc[i];
        w = tot - r;
    endfunction

    function automatic logic [23:0] pk(input int cw, input int v[8]);
        logic [23:0] x;
        x = '0;
        for (int i = 0; i < 8; i++) x = x | (24'(v[i]) << (i * cw));
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear(input int sel);
        m_gc[sel]   = 0;
        m_win[sel]  = 0;
        m_lose[sel] = 0;
    endtask

    task automatic model_update(input int sel, input int r);
        int n;
        n = sel ? 6 : 4;
        if (m_gc[sel] < 8) m_gc[sel]++;
        m_win[sel]  = (r == n) ? 1 : 0;
        m_lose[sel] = (!m_win[sel] && m_gc[sel] == 8) ? 1 : 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start4 = 1'b0; new_game4 = 1'b0; start6 = 1'b0; new_game6 = 1'b0;
        code4 = '0; guess4 = '0; code6 = '0; guess6 = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        model_clear(0);
        model_clear(1);
    endtask

    task automatic pulse_new_game(input int sel);
        if (sel != 0) new_game6 = 1'b1; else new_game4 = 1'b1;
        tick();
        new_game4 = 1'b0;
        new_game6 = 1'b0;
        model_clear(sel);
    endtask

    // Drives one scoring request and returns latency (cycle of done, -1 on
    // timeout), busy cycles seen and the results; ends in the cycle after DONE.
    task automatic do_score(input int sel, input logic [23:0] c, input logic [23:0] g,
                            output int lat, output int bcnt, output int r, output int w);
        cur6 = (sel != 0);
        if (sel != 0) begin
            code6 = c; guess6 = g; start6 = 1'b1;
        end else begin
            code4 = c[11:0]; guess4 = g[11:0]; start4 = 1'b1;
        end
        tick();
        start4 = 1'b0;
        start6 = 1'b0;
        code4 = '1; guess4 = '0; code6 = '1; guess6 = '0;
        lat = 1;
        bcnt = 0;
        while (1) begin
            if (obs_busy) bcnt++;
            if (obs_done || lat >= 60) break;
            tick();
            lat++;
        end
        if (!obs_done) lat = -1;
        r = int'(obs_red);
        w = int'(obs_white);
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({busy4, done4, red4, white4, gc4, win4, lose4} !== 13'd0)
            begin errors++; $display("FAIL reset_outputs: got %b expected 0", {busy4, done4, red4, white4, gc4, win4, lose4}); end
    endtask

    task automatic test_exact();
        int lat, bc, r, w;
        int seen;
        do_score(0, pk(3, '{1, 2, 3, 4, 0, 0, 0, 0}), pk(3, '{1, 2, 3, 4, 0, 0, 0, 0}), lat, bc, r, w);
        model_update(0, 4);
        checks++; if (lat != 9) begin errors++; $display("FAIL exact_latency: got %0d expected 9", lat); end
        checks++; if (bc != 9) begin errors++; $display("FAIL exact_busy_cycles: got %0d expected 9", bc); end
        checks++; if (r != 4 || w != 0) begin errors++; $display("FAIL exact_rw: got %0d/%0d expected 4/0", r, w); end
        checks++; if (win4 !== 1'b1 || gc4 !== 4'd1) begin errors++; $display("FAIL exact_win_count: got win=%0d gc=%0d expected 1/1", win4, gc4); end
        checks++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin errors++; $display("FAIL exact_after_done: got busy=%0d done=%0d expected 0/0", busy4, done4); end
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy4 || done4) seen = 1;
            tick();
        end
        checks++; if (seen != 0 || gc4 !== 4'd1) begin errors++; $display("FAIL exact_start_after_win: got activity=%0d gc=%0d expected 0/1", seen, gc4); end
    endtask

    task automatic test_permutation();
        int lat, bc, r, w;
        pulse_new_game(0);
        do_score(0, pk(3, '{1, 2, 3, 4, 0, 0, 0, 0}), pk(3, '{4, 3, 2, 1, 0, 0, 0, 0}), lat, bc, r, w);
        model_update(0, 0);
        checks++; if (r != 0 || w != 4) begin errors++; $display("FAIL perm_rw: got %0d/%0d expected 0/4", r, w); end
        checks++; if (win4 !== 1'b0 || lose4 !== 1'b0 || gc4 !== 4'd1) begin errors++; $display("FAIL perm_state: got win=%0d lose=%0d gc=%0d expected 0/0/1", win4, lose4, gc4); end
    endtask

    task automatic test_duplicates();
        int lat, bc, r, w;
        do_score(0, pk(3, '{1, 1, 2, 2, 0, 0, 0, 0}), pk(3, '{1, 2, 1, 1, 0, 0, 0, 0}), lat, bc, r, w);
        model_update(0, 1);
        checks++; if (r != 1 || w != 2) begin errors++; $display("FAIL dup_rw: got %0d/%0d expected 1/2", r, w); end
        checks++; if (lat != 9) begin errors++; $display("FAIL dup_back_to_back_latency: got %0d expected 9", lat); end
        do_score(0, pk(3, '{5, 5, 5, 5, 0, 0, 0, 0}), pk(3, '{5, 0, 0, 0, 0, 0, 0, 0}), lat, bc, r, w);
        model_update(0, 1);
        checks++; if (r != 1 || w != 0) begin errors++; $display("FAIL dup_no_double: got %0d/%0d expected 1/0", r, w); end
        checks++; if (gc4 !== 4'd3) begin errors++; $display("FAIL dup_count: got %0d expected 3", gc4); end
    endtask

    task automatic test_loss();
        int lat, bc, r, w;
        int seen;
        pulse_new_game(0);
        for (int i = 0; i < 8; i++) begin
            do_score(0, pk(3, '{1, 2, 3, 4, 0, 0, 0, 0}), '0, lat, bc, r, w);
            model_update(0, r);
        end
        checks++; if (lose4 !== 1'b1 || win4 !== 1'b0 || gc4 !== 4'd8) begin errors++; $display("FAIL loss_state: got lose=%0d win=%0d gc=%0d expected 1/0/8", lose4, win4, gc4); end
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy4 || done4) seen = 1;
            tick();
        end
        checks++; if (seen != 0 || gc4 !== 4'd8) begin errors++; $display("FAIL loss_ninth_start: got activity=%0d gc=%0d expected 0/8", seen, gc4); end
        pulse_new_game(0);
        checks++;
        if ({busy4, done4, red4, white4, gc4, win4, lose4} !== 13'd0)
            begin errors++; $display("FAIL loss_new_game_clear: got %b expected 0", {busy4, done4, red4, white4, gc4, win4, lose4}); end
        do_score(0, pk(3, '{1, 2, 3, 4, 0, 0, 0, 0}), pk(3, '{1, 0, 0, 0, 0, 0, 0, 0}), lat, bc, r, w);
        model_update(0, r);
        checks++; if (lat != 9 || gc4 !== 4'd1) begin errors++; $display("FAIL loss_restart: got lat=%0d gc=%0d expected 9/1", lat, gc4); end
    endtask

    task automatic test_busy_start();
        int dones, first;
        pulse_new_game(0);
        cur6 = 1'b0;
        code4 = pk(3, '{1, 2, 3, 4, 0, 0, 0, 0}) & 24'hfff;
        guess4 = pk(3, '{1, 0, 3, 0, 0, 0, 0, 0}) & 24'hfff;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        dones = 0;
        first = -1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (done4) begin
                dones++;
                if (first < 0) first = cyc;
            end
            start4 = (cyc == 3 || cyc == 6) ? 1'b1 : 1'b0;
            tick();
        end
        start4 = 1'b0;
        model_update(0, 2);
        checks++; if (dones != 1 || first != 9) begin errors++; $display("FAIL busy_start_single_done: got %0d dones at %0d expected 1 at 9", dones, first); end
        checks++; if (red4 !== 3'd2 || gc4 !== 4'd1) begin errors++; $display("FAIL busy_start_result: got red=%0d gc=%0d expected 2/1", red4, gc4); end
    endtask

    task automatic test_new_game_abort();
        int seen;
        cur6 = 1'b0;
        code4 = 12'h0d1;
        guess4 = 12'h0d1;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        new_game4 = 1'b1;
        tick();
        new_game4 = 1'b0;
        model_clear(0);
        checks++;
        if ({busy4, done4, red4, white4, gc4, win4, lose4} !== 13'd0)
            begin errors++; $display("FAIL abort_clear: got %b expected 0", {busy4, done4, red4, white4, gc4, win4, lose4}); end
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (done4 || busy4) seen = 1;
            tick();
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_done: got activity=%0d expected 0", seen); end
    endtask

    task automatic test_async_reset();
        int lat, bc, r, w;
        pulse_new_game(0);
        do_score(0, pk(3, '{1, 2, 3, 4, 0, 0, 0, 0}), pk(3, '{1, 2, 0, 0, 0, 0, 0, 0}), lat, bc, r, w);
        model_update(0, r);
        code4 = 12'h123;
        guess4 = 12'h123;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy4, done4, red4, white4, gc4} !== 11'd0)
            begin errors++; $display("FAIL async_reset_clear: got %b expected 0", {busy4, done4, red4, white4, gc4}); end
        tick();
        reset = 1'b0;
        model_clear(0);
        model_clear(1);
        tick();
        do_score(0, pk(3, '{1, 2, 3, 4, 0, 0, 0, 0}), pk(3, '{2, 1, 3, 0, 0, 0, 0, 0}), lat, bc, r, w);
        model_update(0, 1);
        checks++; if (lat != 9 || r != 1 || w != 2 || gc4 !== 4'd1) begin errors++; $display("FAIL async_reset_rescore: got lat=%0d rw=%0d/%0d gc=%0d expected 9 1/2 1", lat, r, w, gc4); end
    endtask

    task automatic test_n6();
        int lat, bc, r, w;
        pulse_new_game(1);
        do_score(1, pk(4, '{1, 1, 2, 3, 4, 5, 0, 0}), pk(4, '{1, 2, 1, 3, 9, 4, 0, 0}), lat, bc, r, w);
        model_update(1, 2);
        checks++; if (r != 2 || w != 3) begin errors++; $display("FAIL n6_dup_rw: got %0d/%0d expected 2/3", r, w); end
        checks++; if (lat != 13 || bc != 13) begin errors++; $display("FAIL n6_latency: got lat=%0d busy=%0d expected 13/13", lat, bc); end
    endtask

    task automatic test_random();
        logic [23:0] c, g;
        logic [7:0]  exp_rw;
        int sel, n, cw, er, ew, lat, bc, r, w;
        for (int it = 0; it < 30; it++) begin
            sel = int'($urandom_range(0, 1));
            n = sel ? 6 : 4;
            cw = sel ? 4 : 3;
            if (m_win[sel] != 0 || m_lose[sel] != 0) pulse_new_game(sel);
            c = '0;
            g = '0;
            for (int i = 0; i < n; i++) begin
                c = c | (24'($urandom_range(0, 3)) << (i * cw));
                g = g | (24'($urandom_range(0, 3)) << (i * cw));
            end
            if ($urandom_range(0, 5) == 0) g = c;
            ref_rw(n, cw, c, g, er, ew);
            exp_q.push_back({4'(er), 4'(ew)});
            do_score(sel, c, g, lat, bc, r, w);
            model_update(sel, er);
            exp_rw = exp_q.pop_front();
            checks++; if (lat != 2 * n + 1) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", it, lat, 2 * n + 1); end
            checks++; if ({4'(r), 4'(w)} !== exp_rw) begin errors++; $display("FAIL rand_rw[%0d]: got %0d/%0d expected %0d/%0d", it, r, w, exp_rw[7:4], exp_rw[3:0]); end
            checks++;
            if (int'(obs_gc) != m_gc[sel] || int'(obs_win) != m_win[sel] || int'(obs_lose) != m_lose[sel])
                begin errors++; $display("FAIL rand_game[%0d]: got gc=%0d win=%0d lose=%0d expected %0d/%0d/%0d", it, obs_gc, obs_win, obs_lose, m_gc[sel], m_win[sel], m_lose[sel]); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_exact();
        test_permutation();
        test_duplicates();
        test_loss();
        test_busy_start();
        test_new_game_abort();
        test_async_reset();
        test_n6();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
